// File: rtl/rvfi_order_buffer_if.sv
// ---------------------------------------------------------------------------
// rvfi_order_buffer_if
// One RVFI retirement stream: a valid strobe, the order tag and the opaque
// payload bundle. There is no ready signal because the stream has no
// backpressure.
//   valid   : retirement present this cycle
//   order   : ORDER_W-bit order tag
//   payload : PAYLOAD_W-bit retirement bundle
// Modports:
//   master : drives the stream
//   slave  : receives the stream
// ---------------------------------------------------------------------------
interface rvfi_order_buffer_if #(
    parameter int ORDER_W   = 64,
    parameter int PAYLOAD_W = 128
);
    logic                 valid;
    logic [ORDER_W-1:0]   order;
    logic [PAYLOAD_W-1:0] payload;

    modport master (output valid, output order, output payload);
    modport slave  (input  valid, input  order, input  payload);
endinterface

// File: rtl/rvfi_order_buffer.sv
// ---------------------------------------------------------------------------
// rvfi_order_buffer
// Accepts RVFI retirements in any order of their order tag, holds them in a
// window of DEPTH slots indexed by (order mod DEPTH), and re-emits them in
// strictly ascending order, at most one per cycle, from registered outputs.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   in_if  (slave) : incoming retirement stream (valid/order/payload)
//   out_if (master): in-order retirement stream, registered
//   count_o        : number of occupied slots
//   err_window_o   : sticky, an input tag fell outside the window
//   err_dup_o      : sticky, an input tag hit an occupied slot
//   err_timeout_o  : sticky, head stalled for TIMEOUT cycles
// Optional feature: define RISCV_FORMAL_ORDER_TIMEOUT_EN to build the stall
// counter behind err_timeout_o; otherwise err_timeout_o is constant 0.
// ---------------------------------------------------------------------------
module rvfi_order_buffer #(
    parameter int                 ORDER_W     = 64,
    parameter int                 PAYLOAD_W   = 128,
    parameter int                 DEPTH       = 8,
    parameter logic [ORDER_W-1:0] START_ORDER = '0,
    parameter int                 TIMEOUT     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    rvfi_order_buffer_if.slave        in_if,
    rvfi_order_buffer_if.master       out_if,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      err_window_o,
    output logic                      err_dup_o,
    output logic                      err_timeout_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [ORDER_W-1:0]   exp_q, exp_d;
    logic [DEPTH-1:0]     slot_valid_q, slot_valid_d;
    logic [PAYLOAD_W-1:0] slot_payload_q [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [ORDER_W-1:0]   out_order_q, out_order_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic                 err_window_q, err_window_d;
    logic                 err_dup_q, err_dup_d;

    logic [ORDER_W-1:0]   dist_s;
    logic [IDX_W-1:0]     in_idx_s;
    logic [IDX_W-1:0]     head_idx_s;
    logic                 in_window_s;
    logic                 accept_s;
    logic                 bypass_s;
    logic                 store_s;
    logic                 head_hit_s;
    logic                 hit_s;

    // Input classification: modular distance from the head makes order wrap free.
    always_comb begin
        dist_s      = in_if.order - exp_q;
        in_idx_s    = in_if.order[IDX_W-1:0];
        head_idx_s  = exp_q[IDX_W-1:0];
        in_window_s = (dist_s < ORDER_W'(DEPTH));
        accept_s    = in_if.valid & in_window_s & ~slot_valid_q[in_idx_s];
        bypass_s    = accept_s & (in_if.order == exp_q);
        store_s     = accept_s & ~bypass_s;
        head_hit_s  = slot_valid_q[head_idx_s];
        hit_s       = head_hit_s | bypass_s;
    end

    // Next-state for head pointer, slot occupancy, output register and flags.
    // An accepted store never targets the head slot (that would be dist=DEPTH),
    // so the clear and the set below touch different slots.
    always_comb begin
        exp_d         = exp_q;
        slot_valid_d  = slot_valid_q;
        out_valid_d   = 1'b0;
        out_order_d   = out_order_q;
        out_payload_d = out_payload_q;
        count_d       = count_q + CNT_W'(store_s) - CNT_W'(head_hit_s);
        err_window_d  = err_window_q | (in_if.valid & ~in_window_s);
        err_dup_d     = err_dup_q | (in_if.valid & in_window_s & slot_valid_q[in_idx_s]);
        if (hit_s) begin
            out_valid_d = 1'b1;
            out_order_d = exp_q;
            exp_d       = exp_q + ORDER_W'(1);
            if (bypass_s) begin
                out_payload_d = in_if.payload;
            end else begin
                out_payload_d = slot_payload_q[head_idx_s];
            end
        end else begin
            out_valid_d = 1'b0;
        end
        if (head_hit_s) begin
            slot_valid_d[head_idx_s] = 1'b0;
        end else begin
            slot_valid_d = slot_valid_d;
        end
        if (store_s) begin
            slot_valid_d[in_idx_s] = 1'b1;
        end else begin
            slot_valid_d = slot_valid_d;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q         <= START_ORDER;
            slot_valid_q  <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_order_q   <= '0;
            out_payload_q <= '0;
            err_window_q  <= 1'b0;
            err_dup_q     <= 1'b0;
        end else begin
            exp_q         <= exp_d;
            slot_valid_q  <= slot_valid_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_order_q   <= out_order_d;
            out_payload_q <= out_payload_d;
            err_window_q  <= err_window_d;
            err_dup_q     <= err_dup_d;
        end
    end

    // Slot payload storage; contents are qualified by slot_valid_q so no reset needed.
    always_ff @(posedge clk) begin
        if (store_s) begin
            slot_payload_q[in_idx_s] <= in_if.payload;
        end
    end

`ifdef RISCV_FORMAL_ORDER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_timeout_q, err_timeout_d;

    // Stall counter: counts cycles with buffered entries but no emit, saturating.
    always_comb begin
        stall_d       = stall_q;
        err_timeout_d = err_timeout_q;
        if (hit_s) begin
            stall_d = '0;
        end else if ((count_q != '0) && (stall_q != STALL_W'(TIMEOUT))) begin
            stall_d = stall_q + STALL_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (stall_d == STALL_W'(TIMEOUT)) begin
            err_timeout_d = 1'b1;
        end else begin
            err_timeout_d = err_timeout_q;
        end
    end

    // Stall counter and sticky timeout flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout_o = err_timeout_q;
`else
    // Stall detection compiled out; TIMEOUT is referenced only so the
    // parameter list stays identical between builds.
    assign err_timeout_o = 1'b0 & (TIMEOUT > 0);
`endif

    assign out_if.valid   = out_valid_q;
    assign out_if.order   = out_order_q;
    assign out_if.payload = out_payload_q;
    assign count_o        = count_q;
    assign err_window_o   = err_window_q;
    assign err_dup_o      = err_dup_q;
endmodule

// File: tb/tb_rvfi_order_buffer.sv
module tb_rvfi_order_buffer;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

`ifdef RISCV_FORMAL_ORDER_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    // Main instance: ORDER_W=64, DEPTH=8, START_ORDER=0, TIMEOUT=4
    rvfi_order_buffer_if #(.ORDER_W(64), .PAYLOAD_W(128)) in_a ();
    rvfi_order_buffer_if #(.ORDER_W(64), .PAYLOAD_W(128)) out_a ();
    logic [3:0] cnt_a;
    logic       ew_a, ed_a, et_a;

    rvfi_order_buffer #(
        .ORDER_W(64), .PAYLOAD_W(128), .DEPTH(8),
        .START_ORDER(64'd0), .TIMEOUT(4)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_if(in_a.slave), .out_if(out_a.master),
        .count_o(cnt_a), .err_window_o(ew_a), .err_dup_o(ed_a), .err_timeout_o(et_a)
    );

    // Wrap instance: ORDER_W=8, START_ORDER=254
    rvfi_order_buffer_if #(.ORDER_W(8), .PAYLOAD_W(16)) in_b ();
    rvfi_order_buffer_if #(.ORDER_W(8), .PAYLOAD_W(16)) out_b ();
    logic [3:0] cnt_b;
    logic       ew_b, ed_b, et_b;

    rvfi_order_buffer #(
        .ORDER_W(8), .PAYLOAD_W(16), .DEPTH(8),
        .START_ORDER(8'd254), .TIMEOUT(64)
    ) u_wrap (
        .clk(clk), .reset(reset),
        .in_if(in_b.slave), .out_if(out_b.master),
        .count_o(cnt_b), .err_window_o(ew_b), .err_dup_o(ed_b), .err_timeout_o(et_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_a(input logic v, input logic [63:0] o, input logic [127:0] p);
        in_a.valid   = v;
        in_a.order   = o;
        in_a.payload = p;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] o, input logic [15:0] p);
        in_b.valid   = v;
        in_b.order   = o;
        in_b.payload = p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_a(1'b0, 64'd0, 128'd0);
        drive_b(1'b0, 8'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({out_a.valid, out_a.order, out_a.payload, cnt_a, ew_a, ed_a, et_a} !== '0) begin
            tests_failed++;
            $display("FAIL reset_a: valid=%0b order=%0h payload=%0h count=%0d ew=%0b ed=%0b et=%0b, expected all 0",
                     out_a.valid, out_a.order, out_a.payload, cnt_a, ew_a, ed_a, et_a);
        end
        tests_run++;
        if ({out_b.valid, out_b.order, out_b.payload, cnt_b, ew_b, ed_b, et_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_b: valid=%0b order=%0h payload=%0h count=%0d, expected all 0",
                     out_b.valid, out_b.order, out_b.payload, cnt_b);
        end
    endtask

    task automatic test_in_order();
        logic [127:0] pay [3];
        pay[0] = 128'hA; pay[1] = 128'hB; pay[2] = 128'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 64'(i), pay[i]);
            @(negedge clk);
            tests_run++;
            if (out_a.valid !== 1'b1 || out_a.order !== 64'(i) || out_a.payload !== pay[i] || cnt_a !== 4'd0) begin
                tests_failed++;
                $display("FAIL in_order[%0d]: got v=%0b o=%0d p=%0h cnt=%0d, expected v=1 o=%0d p=%0h cnt=0",
                         i, out_a.valid, out_a.order, out_a.payload, cnt_a, i, pay[i]);
            end
        end
        drive_a(1'b0, 64'd0, 128'd0);
        @(negedge clk);
        tests_run++;
        if (out_a.valid !== 1'b0 || out_a.payload !== 128'hC) begin
            tests_failed++;
            $display("FAIL in_order_idle: got v=%0b p=%0h, expected v=0 p=c (held)", out_a.valid, out_a.payload);
        end
    endtask

    task automatic test_reordered();
        do_reset();
        drive_a(1'b1, 64'd2, 128'h22);
        @(negedge clk);
        tests_run++;
        if (cnt_a !== 4'd1 || out_a.valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reorder_c1: got cnt=%0d v=%0b, expected cnt=1 v=0", cnt_a, out_a.valid);
        end
        drive_a(1'b1, 64'd1, 128'h21);
        @(negedge clk);
        tests_run++;
        if (cnt_a !== 4'd2 || out_a.valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reorder_c2: got cnt=%0d v=%0b, expected cnt=2 v=0", cnt_a, out_a.valid);
        end
        drive_a(1'b1, 64'd0, 128'h20);
        @(negedge clk);
        drive_a(1'b0, 64'd0, 128'd0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_a.valid !== 1'b1 || out_a.order !== 64'(i) || out_a.payload !== 128'(32 + i) ||
                cnt_a !== 4'(i == 0 ? 2 : 2 - i)) begin
                tests_failed++;
                $display("FAIL reorder_emit[%0d]: got v=%0b o=%0d p=%0h cnt=%0d, expected v=1 o=%0d p=%0h cnt=%0d",
                         i, out_a.valid, out_a.order, out_a.payload, cnt_a, i, 32 + i, (i == 0 ? 2 : 2 - i));
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_a.valid !== 1'b0 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL reorder_end: got v=%0b cnt=%0d, expected v=0 cnt=0", out_a.valid, cnt_a);
        end
    endtask

    task automatic test_window();
        do_reset();
        drive_a(1'b1, 64'd8, 128'h88);
        @(negedge clk);
        tests_run++;
        if (ew_a !== 1'b1 || cnt_a !== 4'd0 || out_a.valid !== 1'b0 || ed_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL window_err: got ew=%0b cnt=%0d v=%0b ed=%0b, expected ew=1 cnt=0 v=0 ed=0",
                     ew_a, cnt_a, out_a.valid, ed_a);
        end
        drive_a(1'b1, 64'd0, 128'h77);
        @(negedge clk);
        drive_a(1'b0, 64'd0, 128'd0);
        tests_run++;
        if (out_a.valid !== 1'b1 || out_a.order !== 64'd0 || out_a.payload !== 128'h77 || ew_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL window_follow: got v=%0b o=%0d p=%0h ew=%0b, expected v=1 o=0 p=77 ew=1",
                     out_a.valid, out_a.order, out_a.payload, ew_a);
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        drive_a(1'b1, 64'd3, 128'h33);
        @(negedge clk);
        drive_a(1'b1, 64'd3, 128'h44);
        @(negedge clk);
        tests_run++;
        if (ed_a !== 1'b1 || cnt_a !== 4'd1 || ew_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL dup_flag: got ed=%0b cnt=%0d ew=%0b, expected ed=1 cnt=1 ew=0", ed_a, cnt_a, ew_a);
        end
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 64'(i), 128'(16'hD0 + i));
            @(negedge clk);
        end
        drive_a(1'b0, 64'd0, 128'd0);
        // order 2 was just emitted; order 3 follows from its slot
        @(negedge clk);
        tests_run++;
        if (out_a.valid !== 1'b1 || out_a.order !== 64'd3 || out_a.payload !== 128'h33 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL dup_keep: got v=%0b o=%0d p=%0h cnt=%0d, expected v=1 o=3 p=33 cnt=0",
                     out_a.valid, out_a.order, out_a.payload, cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 7; k >= 1; k--) begin
            drive_a(1'b1, 64'(k), 128'(256 + k));
            @(negedge clk);
        end
        tests_run++;
        if (cnt_a !== 4'd7 || out_a.valid !== 1'b0 || ew_a !== 1'b0 || ed_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_count: got cnt=%0d v=%0b ew=%0b ed=%0b, expected cnt=7 v=0 ew=0 ed=0",
                     cnt_a, out_a.valid, ew_a, ed_a);
        end
        drive_a(1'b1, 64'd0, 128'h100);
        @(negedge clk);
        drive_a(1'b0, 64'd0, 128'd0);
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (out_a.valid !== 1'b1 || out_a.order !== 64'(k) || out_a.payload !== 128'(256 + k)) begin
                tests_failed++;
                $display("FAIL drain[%0d]: got v=%0b o=%0d p=%0h, expected v=1 o=%0d p=%0h",
                         k, out_a.valid, out_a.order, out_a.payload, k, 256 + k);
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_a.valid !== 1'b0 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL drain_end: got v=%0b cnt=%0d, expected v=0 cnt=0", out_a.valid, cnt_a);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ins [4];
        logic [7:0] outs [4];
        ins[0] = 8'd255; ins[1] = 8'd254; ins[2] = 8'd1; ins[3] = 8'd0;
        outs[0] = 8'd254; outs[1] = 8'd255; outs[2] = 8'd0; outs[3] = 8'd1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive_b(1'b1, ins[i], {8'hB0, ins[i]});
            end else begin
                drive_b(1'b0, 8'd0, 16'd0);
            end
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                tests_run++;
                if (out_b.valid !== 1'b1 || out_b.order !== outs[i-1] || out_b.payload !== {8'hB0, outs[i-1]}) begin
                    tests_failed++;
                    $display("FAIL wrap[%0d]: got v=%0b o=%0d p=%0h, expected v=1 o=%0d p=%0h",
                             i - 1, out_b.valid, out_b.order, out_b.payload, outs[i-1], {8'hB0, outs[i-1]});
                end
            end
        end
        tests_run++;
        if (out_b.valid !== 1'b0 || cnt_b !== 4'd0 || ew_b !== 1'b0 || ed_b !== 1'b0 || et_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end: got v=%0b cnt=%0d ew=%0b ed=%0b et=%0b, expected all 0",
                     out_b.valid, cnt_b, ew_b, ed_b, et_b);
        end
    endtask

    task automatic test_timeout_reset();
        do_reset();
        drive_a(1'b1, 64'd0, 128'h5A);
        @(negedge clk);
        drive_a(1'b1, 64'd2, 128'h52);
        @(negedge clk);
        drive_a(1'b0, 64'd0, 128'd0);
        // order 2 buffered, order 1 missing: stalled cycles begin now
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            tests_run++;
            if (et_a !== (s == 4 ? TO_EN : 1'b0) || out_a.valid !== 1'b0 || out_a.payload !== 128'h5A) begin
                tests_failed++;
                $display("FAIL timeout[%0d]: got et=%0b v=%0b p=%0h, expected et=%0b v=0 p=5a",
                         s, et_a, out_a.valid, out_a.payload, (s == 4 ? TO_EN : 1'b0));
            end
        end
        drive_a(1'b1, 64'd9, 128'h99);
        @(negedge clk);
        drive_a(1'b0, 64'd0, 128'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({out_a.valid, out_a.order, out_a.payload, cnt_a, ew_a, ed_a, et_a} !== '0) begin
            tests_failed++;
            $display("FAIL midreset: got v=%0b o=%0d p=%0h cnt=%0d ew=%0b ed=%0b et=%0b, expected all 0",
                     out_a.valid, out_a.order, out_a.payload, cnt_a, ew_a, ed_a, et_a);
        end
        // stale order 2 must be gone: feed 0,1 and expect the stream to stop
        drive_a(1'b1, 64'd0, 128'hE0);
        @(negedge clk);
        drive_a(1'b1, 64'd1, 128'hE1);
        @(negedge clk);
        drive_a(1'b0, 64'd0, 128'd0);
        @(negedge clk);
        tests_run++;
        if (out_a.valid !== 1'b0 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL midreset_discard: got v=%0b o=%0d cnt=%0d, expected v=0 cnt=0",
                     out_a.valid, out_a.order, cnt_a);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        drive_a(1'b0, 64'd0, 128'd0);
        drive_b(1'b0, 8'd0, 16'd0);
        test_reset();
        test_in_order();
        test_reordered();
        test_window();
        test_duplicate();
        test_back_to_back();
        test_wrap();
        test_timeout_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
